branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution in the decode stage of the pipelined CPU.
- Consumes CBZ/CBNZ operands through a 64-bit zero detector and B.LT conditions through a local NZCV flag register.
- Stalls decode while an operand or flag producer is still in flight.
- Issues a one-cycle taken/flush pulse to fetch and the IF/ID register.

Parameters:
- DATA_W, 64, width of the CBZ/CBNZ register operand.
- WAIT_MAX, 15, maximum hazard-wait cycles before the error flag sets. The counter is sized clog2(WAIT_MAX+1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- br_valid  input  1  decode presents a branch; must hold stable with br_type/br_operand while br_ready=0.
- br_type  input  2  00 B, 01 CBZ, 10 CBNZ, 11 B.LT.
- br_operand  input  DATA_W  forwarded Rt value for CBZ/CBNZ.
- op_pending  input  1  Rt produced by a load not yet forwardable.
- flags_pending  input  1  flag-setting instruction in EX that has not yet written.
- flags_wr  input  1  EX writes flags this cycle.
- flags_in  input  4  NZCV from the ALU.
- br_ready  output  1  branch accepted this cycle (combinational).
- stall  output  1  hold PC and IF/ID (combinational).
- take  output  1  registered pulse: redirect PC to the branch target.
- flush  output  1  registered pulse: squash IF/ID.
- flags_q  output  4  current NZCV register.
- wait_err  output  1  sticky; set when a wait exceeds WAIT_MAX.

Behaviour:
- Reset values: flags_q=0, take=0, flush=0, wait_err=0, state=IDLE, wait counter=0. Reset has priority over every other event.
- Flag register:
  - flags_wr=1 loads flags_in at the edge.
  - During evaluation, the effective flags are flags_in when flags_wr=1 (same-cycle bypass), else flags_q.
- Hazard definition:
  - hz = (type CBZ/CBNZ and op_pending) or (type B.LT and flags_pending and not flags_wr).
  - Type B never hazards.
- Condition evaluation:
  - B always taken.
  - CBZ taken iff br_operand==0.
  - CBNZ taken iff br_operand!=0.
  - B.LT taken iff N!=V on the effective flags.
- FSM states:
  - IDLE:
    - br_valid & !hz: br_ready=1, stall=0. If taken, go to SQUASH; else stay in IDLE.
    - br_valid & hz: br_ready=0, stall=1, go to WAIT, clear the wait counter.
  - WAIT:
    - stall=1, br_ready=0 while hz; the counter increments.
    - When the counter reaches WAIT_MAX, set wait_err and keep waiting (no forced resolution).
    - When hz clears: br_ready=1, stall=0, evaluate. Taken goes to SQUASH, not-taken goes to IDLE.
    - br_valid dropping in WAIT means decode was flushed externally: go to IDLE without asserting take.
  - SQUASH (exactly one cycle):
    - take=1, flush=1.
    - br_valid ignored and br_ready=0, because the decode instruction is wrong-path.
    - Always returns to IDLE.
- Latency: resolution is in the acceptance cycle; take/flush appear the following cycle. A not-taken branch never asserts take/flush.
- Back-to-back: a not-taken branch accepted in IDLE lets the next branch be accepted on the following cycle.
- Reset mid-WAIT or mid-SQUASH: returns to IDLE and suppresses pending pulses.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined:
  - Add outputs taken_cnt[31:0], nottaken_cnt[31:0] and stall_cnt[31:0].
  - Counters increment on each resolved-taken branch, each resolved-not-taken branch, and each stall cycle respectively.
  - Counters wrap from 0xFFFFFFFF to 0 and clear on reset.
- When undefined: the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package branch_pkg holds:
  - br_type_e enum (BR_B, BR_CBZ, BR_CBNZ, BR_BLT).
  - ctrl_state_e enum (IDLE, WAIT, SQUASH).
  - NZCV bit-index constants (N=3, Z=2, C=1, V=0).
- One combinational sub-module, branch_cond_eval:
  - Inputs: type, operand, effective flags.
  - Output: taken.
  - Instantiates the existing 64-bit zero detector for CBZ/CBNZ.

Test Plan:
- CBZ, operand=0, no hazard, from IDLE → br_ready=1 that cycle; take=flush=1 next cycle for exactly one cycle; br_valid during SQUASH not accepted.
- CBNZ, operand=64'h1, with op_pending high 3 cycles → stall=1 for 3 cycles, br_ready at cycle 4, take pulse at cycle 5.
- Flag bypass:
  - Setup: flags_q=0, flags_pending=1, flags_wr=1 with flags_in=4'b1000, B.LT presented in the same cycle.
  - Expected: no stall, taken, flags_q=1000 next cycle.
- CBZ, operand=64'hFFFF_0000_0000_0000 → not taken, no take/flush; next-cycle B accepted, then take pulse.
- Reset in WAIT after op_pending held 20 cycles:
  - Before reset: wait_err=1 after WAIT_MAX (15) wait cycles.
  - Reset asserted one cycle: state IDLE, wait_err=0, no take pulse.
- With BRANCH_STATS_EN: 2 taken, 1 not-taken, 3 stall cycles → counters read 2/1/3; after reset all read 0.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types for the decode-stage branch resolution controller.
package branch_pkg;

    localparam int unsigned NZCV_W = 4;
    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

    typedef enum logic [1:0] {
        BR_B    = 2'b00,
        BR_CBZ  = 2'b01,
        BR_CBNZ = 2'b10,
        BR_BLT  = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        SQUASH = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decode <-> branch controller signal bundle; BRANCH_STATS_EN adds statistics counters.
interface branch_resolve_ctrl_if #(
    parameter int unsigned DATA_W = 64
);
    logic              br_valid;
    logic [1:0]        br_type;
    logic [DATA_W-1:0] br_operand;
    logic              op_pending;
    logic              flags_pending;
    logic              flags_wr;
    logic [3:0]        flags_in;
    logic              br_ready;
    logic              stall;
    logic              take;
    logic              flush;
    logic [3:0]        flags_q;
    logic              wait_err;
`ifdef BRANCH_STATS_EN
    logic [31:0]       taken_cnt;
    logic [31:0]       nottaken_cnt;
    logic [31:0]       stall_cnt;
`endif

    modport master (
        output br_valid, br_type, br_operand, op_pending, flags_pending, flags_wr, flags_in,
`ifdef BRANCH_STATS_EN
        input  taken_cnt, nottaken_cnt, stall_cnt,
`endif
        input  br_ready, stall, take, flush, flags_q, wait_err
    );

    modport slave (
        input  br_valid, br_type, br_operand, op_pending, flags_pending, flags_wr, flags_in,
`ifdef BRANCH_STATS_EN
        output taken_cnt, nottaken_cnt, stall_cnt,
`endif
        output br_ready, stall, take, flush, flags_q, wait_err
    );

endinterface

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Combinational taken/not-taken decision for B, CBZ, CBNZ and B.LT.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  br_type_e          i_type,
    input  logic [DATA_W-1:0] i_operand,
    input  logic [NZCV_W-1:0] i_flags,
    output logic              o_taken
);
    logic w_zero;

    zero_detect64 u_zero_detect (
        .i_data (64'(i_operand)),
        .o_zero (w_zero)
    );

    always_comb begin
        o_taken = 1'b0;
        unique case (i_type)
            BR_B:    o_taken = 1'b1;
            BR_CBZ:  o_taken = w_zero;
            BR_CBNZ: o_taken = ~w_zero;
            BR_BLT:  o_taken = i_flags[NZCV_N] ^ i_flags[NZCV_V];
            default: o_taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/zero_detect64.sv
// 64-bit zero detector used by the branch condition evaluator.
module zero_detect64 (
    input  logic [63:0] i_data,
    output logic        o_zero
);
    assign o_zero = ~(|i_data);
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch resolution: hazard stall, condition evaluation, take/flush pulse.
// Optional statistics counters enabled with BRANCH_STATS_EN.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    ctrl_state_e       r_state;
    ctrl_state_e       w_next_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [NZCV_W-1:0] r_flags;
    logic [NZCV_W-1:0] w_eff_flags;
    logic              r_take;
    logic              r_flush;
    logic              r_wait_err;
    logic              w_hz;
    logic              w_taken;
    logic              w_accept;
    logic              w_stall;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    br_type_e          w_type;

    assign w_type      = br_type_e'(bus.br_type);
    // A flag write in the same cycle both resolves the hazard and supplies the value.
    assign w_eff_flags = bus.flags_wr ? bus.flags_in : r_flags;
    assign w_hz        = (((w_type == BR_CBZ) || (w_type == BR_CBNZ)) && bus.op_pending)
                       || ((w_type == BR_BLT) && bus.flags_pending && !bus.flags_wr);

    branch_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
        .i_type    (w_type),
        .i_operand (bus.br_operand),
        .i_flags   (w_eff_flags),
        .o_taken   (w_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_stall      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.br_valid) begin
                    if (w_hz) begin
                        w_stall      = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_next_state = WAIT;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = w_taken ? SQUASH : IDLE;
                    end
                end
            end
            WAIT: begin
                // Decode was squashed underneath us: abandon the branch silently.
                if (!bus.br_valid) begin
                    w_next_state = IDLE;
                end else if (w_hz) begin
                    w_stall   = 1'b1;
                    w_cnt_inc = 1'b1;
                end else begin
                    w_accept     = 1'b1;
                    w_next_state = w_taken ? SQUASH : IDLE;
                end
            end
            SQUASH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_take     <= 1'b0;
            r_flush    <= 1'b0;
            r_flags    <= '0;
            r_wait_cnt <= '0;
            r_wait_err <= 1'b0;
        end else begin
            r_take  <= w_accept & w_taken;
            r_flush <= w_accept & w_taken;
            if (bus.flags_wr) r_flags <= bus.flags_in;
            if (w_cnt_clr) begin
                r_wait_cnt <= '0;
            end else if (w_cnt_inc) begin
                if (r_wait_cnt != CNT_W'(WAIT_MAX)) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                // Sticky error once the counter reaches its ceiling; waiting continues.
                if (r_wait_cnt >= CNT_W'(WAIT_MAX - 1)) r_wait_err <= 1'b1;
            end
        end
    end

    assign bus.br_ready = w_accept;
    assign bus.stall    = w_stall;
    assign bus.take     = r_take;
    assign bus.flush    = r_flush;
    assign bus.flags_q  = r_flags;
    assign bus.wait_err = r_wait_err;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_taken_cnt;
    logic [31:0] r_nottaken_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken_cnt    <= '0;
            r_nottaken_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_accept && w_taken)  r_taken_cnt    <= r_taken_cnt + 32'd1;
            if (w_accept && !w_taken) r_nottaken_cnt <= r_nottaken_cnt + 32'd1;
            if (w_stall)              r_stall_cnt    <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.taken_cnt    = r_taken_cnt;
    assign bus.nottaken_cnt = r_nottaken_cnt;
    assign bus.stall_cnt    = r_stall_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; statistics checks run when BRANCH_STATS_EN is defined.
module tb_branch_resolve_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    branch_resolve_ctrl_if #(.DATA_W(64)) bus ();

    branch_resolve_ctrl #(.DATA_W(64), .WAIT_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_br(input logic v, input logic [1:0] t, input logic [63:0] op);
        bus.br_valid   = v;
        bus.br_type    = t;
        bus.br_operand = op;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_br(1'b0, 2'b00, 64'd0);
        bus.op_pending    = 1'b0;
        bus.flags_pending = 1'b0;
        bus.flags_wr      = 1'b0;
        bus.flags_in      = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_flags_q", 64'(bus.flags_q), 64'h0);
        chk("rst_take", 64'(bus.take), 64'h0);
        chk("rst_flush", 64'(bus.flush), 64'h0);
        chk("rst_wait_err", 64'(bus.wait_err), 64'h0);
        chk("rst_stall", 64'(bus.stall), 64'h0);

        // CBZ zero operand: accepted immediately, one-cycle pulse, SQUASH ignores decode
        set_br(1'b1, 2'b01, 64'h0);
        #1;
        chk("cbz_ready", 64'(bus.br_ready), 64'h1);
        chk("cbz_stall", 64'(bus.stall), 64'h0);
        tick();
        chk("cbz_take", 64'(bus.take), 64'h1);
        chk("cbz_flush", 64'(bus.flush), 64'h1);
        chk("squash_no_ready", 64'(bus.br_ready), 64'h0);
        set_br(1'b0, 2'b00, 64'h0);
        tick();
        chk("cbz_take_end", 64'(bus.take), 64'h0);
        chk("cbz_flush_end", 64'(bus.flush), 64'h0);

        // CBNZ with op_pending for 3 cycles
        set_br(1'b1, 2'b10, 64'h1);
        bus.op_pending = 1'b1;
        #1;
        chk("cbnz_stall1", 64'(bus.stall), 64'h1);
        chk("cbnz_ready1", 64'(bus.br_ready), 64'h0);
        tick();
        chk("cbnz_stall2", 64'(bus.stall), 64'h1);
        tick();
        chk("cbnz_stall3", 64'(bus.stall), 64'h1);
        chk("cbnz_no_take", 64'(bus.take), 64'h0);
        tick();
        bus.op_pending = 1'b0;
        #1;
        chk("cbnz_ready4", 64'(bus.br_ready), 64'h1);
        chk("cbnz_stall4", 64'(bus.stall), 64'h0);
        tick();
        chk("cbnz_take5", 64'(bus.take), 64'h1);
        set_br(1'b0, 2'b00, 64'h0);
        tick();
        chk("cbnz_take_end", 64'(bus.take), 64'h0);

        // B.LT with same-cycle flag bypass (N=1, V=0 -> taken)
        bus.flags_pending = 1'b1;
        bus.flags_wr      = 1'b1;
        bus.flags_in      = 4'b1000;
        set_br(1'b1, 2'b11, 64'h0);
        #1;
        chk("blt_byp_stall", 64'(bus.stall), 64'h0);
        chk("blt_byp_ready", 64'(bus.br_ready), 64'h1);
        tick();
        chk("blt_byp_take", 64'(bus.take), 64'h1);
        chk("blt_byp_flags", 64'(bus.flags_q), 64'h8);
        bus.flags_pending = 1'b0;
        bus.flags_wr      = 1'b0;
        set_br(1'b0, 2'b00, 64'h0);
        tick();

        // Load N=1,V=1 then B.LT resolves not-taken from the register
        bus.flags_wr = 1'b1;
        bus.flags_in = 4'b1001;
        tick();
        bus.flags_wr = 1'b0;
        bus.flags_in = 4'b0000;
        chk("flags_load", 64'(bus.flags_q), 64'h9);
        set_br(1'b1, 2'b11, 64'h0);
        #1;
        chk("blt_nt_ready", 64'(bus.br_ready), 64'h1);
        tick();
        chk("blt_nt_take", 64'(bus.take), 64'h0);

        // B.LT flag hazard, resolved in WAIT by a write of V only -> taken
        bus.flags_pending = 1'b1;
        #1;
        chk("blt_hz_stall", 64'(bus.stall), 64'h1);
        tick();
        bus.flags_wr = 1'b1;
        bus.flags_in = 4'b0001;
        #1;
        chk("blt_wait_ready", 64'(bus.br_ready), 64'h1);
        tick();
        chk("blt_wait_take", 64'(bus.take), 64'h1);
        bus.flags_pending = 1'b0;
        bus.flags_wr      = 1'b0;
        set_br(1'b0, 2'b00, 64'h0);
        tick();

        // CBZ non-zero: not taken, then back-to-back B accepted next cycle
        set_br(1'b1, 2'b01, 64'hFFFF_0000_0000_0000);
        #1;
        chk("cbz_nt_ready", 64'(bus.br_ready), 64'h1);
        tick();
        chk("cbz_nt_take", 64'(bus.take), 64'h0);
        chk("cbz_nt_flush", 64'(bus.flush), 64'h0);
        set_br(1'b1, 2'b00, 64'h0);
        #1;
        chk("b2b_ready", 64'(bus.br_ready), 64'h1);
        tick();
        chk("b2b_take", 64'(bus.take), 64'h1);
        set_br(1'b0, 2'b00, 64'h0);
        tick();

        // br_valid drop in WAIT abandons the branch
        set_br(1'b1, 2'b01, 64'h0);
        bus.op_pending = 1'b1;
        tick();
        set_br(1'b0, 2'b01, 64'h0);
        #1;
        chk("drop_ready", 64'(bus.br_ready), 64'h0);
        chk("drop_stall", 64'(bus.stall), 64'h0);
        tick();
        chk("drop_take", 64'(bus.take), 64'h0);
        bus.op_pending = 1'b0;
        set_br(1'b1, 2'b00, 64'h0);
        #1;
        chk("drop_idle_ready", 64'(bus.br_ready), 64'h1);
        tick();
        set_br(1'b0, 2'b00, 64'h0);
        tick();

        // Hazard held 20 cycles: wait_err after 15 WAIT cycles, then reset mid-WAIT
        set_br(1'b1, 2'b01, 64'h0);
        bus.op_pending = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("werr_before", 64'(bus.wait_err), 64'h0);
        tick();
        chk("werr_set", 64'(bus.wait_err), 64'h1);
        for (int i = 0; i < 4; i++) tick();
        chk("werr_sticky", 64'(bus.wait_err), 64'h1);
        chk("werr_still_stall", 64'(bus.stall), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.op_pending = 1'b0;
        set_br(1'b0, 2'b00, 64'h0);
        #1;
        chk("rstw_wait_err", 64'(bus.wait_err), 64'h0);
        chk("rstw_take", 64'(bus.take), 64'h0);
        chk("rstw_stall", 64'(bus.stall), 64'h0);
        tick();
        chk("rstw_take2", 64'(bus.take), 64'h0);
        set_br(1'b1, 2'b00, 64'h0);
        #1;
        chk("rstw_idle_ready", 64'(bus.br_ready), 64'h1);
        tick();
        set_br(1'b0, 2'b00, 64'h0);
        tick();

`ifdef BRANCH_STATS_EN
        // Statistics: 2 taken, 1 not-taken, 3 stall cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_br(1'b1, 2'b00, 64'h0);
        tick();
        set_br(1'b0, 2'b00, 64'h0);
        tick();
        set_br(1'b1, 2'b10, 64'h0);
        tick();
        set_br(1'b1, 2'b01, 64'h0);
        bus.op_pending = 1'b1;
        tick();
        tick();
        tick();
        bus.op_pending = 1'b0;
        tick();
        set_br(1'b0, 2'b00, 64'h0);
        tick();
        chk("stat_taken", 64'(bus.taken_cnt), 64'd2);
        chk("stat_nottaken", 64'(bus.nottaken_cnt), 64'd1);
        chk("stat_stall", 64'(bus.stall_cnt), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("stat_rst_taken", 64'(bus.taken_cnt), 64'd0);
        chk("stat_rst_nottaken", 64'(bus.nottaken_cnt), 64'd0);
        chk("stat_rst_stall", 64'(bus.stall_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
